ea_sequencer: RTL and testbench
===============================

Name: ea_sequencer

Overview:
- Parametrised multi-cycle effective-address sequencer for the 6502-style core.
- Replaces hard-wired lo/hi/indirect/carry address states with a stand-alone block. Block fetches operand and pointer bytes over a ready/request memory handshake with wait-state support.
- Computes the effective address for all eight addressing modes and reports operand length and page crossing to the control FSM.

Parameters:
- DATA_W, 8, data/byte width. ADDR_W is always 2*DATA_W.
- ADDR_W, 16, address width. Must equal 2*DATA_W.
- PAGE_PENALTY, 1, when 1 an indexed load that crosses a page takes the FIX cycle; when 0 only stores take FIX.

Ports:
- CLK  in  1  clock, all logic on rising edge
- R  in  1  reset, synchronous, active-low
- START  in  1  request; accepted only when BUSY=0
- MODE  in  3  0 IMM, 1 ZP, 2 ZP_X, 3 ABS, 4 ABS_X, 5 ABS_Y, 6 IND_X (zp,x), 7 IND_Y (zp),y
- IS_STORE  in  1  access is a write; forces FIX on indexed modes
- PC_IN  in  ADDR_W  address of first operand byte
- X_IN, Y_IN  in  DATA_W each  index registers
- MEM_REQ  out  1  read request
- MEM_ADDR  out  ADDR_W  read address; 0 when MEM_REQ=0
- MEM_RDY  in  1  read data valid this cycle
- MEM_RDATA  in  DATA_W  read data
- BUSY  out  1  high in every state except IDLE
- DONE  out  1  one-cycle completion pulse
- EA  out  ADDR_W  effective address
- PC_ADV  out  2  operand bytes consumed (1 or 2)
- PAGE_X  out  1  index addition carried into the high byte

Behaviour:
- Reset (R=0 at a CLK edge):
  - State goes to IDLE.
  - MEM_REQ, BUSY, DONE, EA, PC_ADV, PAGE_X and all latches go to 0.
  - Reset aborts any transaction, including one held in a wait state.
- Acceptance:
  - In IDLE with START=1, the block latches MODE, IS_STORE, PC_IN, X_IN and Y_IN.
  - Later changes on these inputs are ignored until the next acceptance.
  - START is ignored while BUSY=1.
- States: IDLE, OP_LO, OP_HI, PTR_LO, PTR_HI, FIX, FIN.
- Memory states (OP_LO, OP_HI, PTR_LO, PTR_HI):
  - MEM_REQ=1 and MEM_ADDR is held stable until MEM_RDY=1.
  - The byte is captured on that edge and the state advances.
  - Each MEM_RDY=0 cycle adds exactly one cycle. MEM_RDY is ignored when MEM_REQ=0.
- Mode sequences (b = OP_LO byte, h = OP_HI byte; adds are modulo 2^DATA_W unless stated):
  - IMM: IDLE -> FIN. EA=PC, PC_ADV=1.
  - ZP: OP_LO@PC -> FIN. EA={0,b}, PC_ADV=1.
  - ZP_X: OP_LO -> FIN. EA={0,b+X} (zero-page wrap, no carry), PC_ADV=1, PAGE_X=0.
  - ABS: OP_LO@PC -> OP_HI@PC+1 -> FIN. EA={h,b}, PC_ADV=2.
  - ABS_X / ABS_Y: same fetches as ABS. sum = b+idx (DATA_W+1 bits). PAGE_X=carry. EA={h+carry, sum[DATA_W-1:0]}.
  - IND_X: OP_LO -> PTR_LO@{0,b+X} -> PTR_HI@{0,b+X+1} (wraps within page 0) -> FIN. EA={ph,pl}, PC_ADV=1.
  - IND_Y: OP_LO -> PTR_LO@{0,b} -> PTR_HI@{0,b+1} (wraps) -> FIN. EA={ph,pl}+Y with the same carry/PAGE_X rule as ABS_X.
- FIX rule (ABS_X, ABS_Y, IND_Y only):
  - The last fetch state goes to FIX when IS_STORE=1, or when PAGE_X=1 and PAGE_PENALTY=1.
  - Otherwise it goes straight to FIN.
  - FIX lasts one cycle, issues no memory request, and goes to FIN.
- Address arithmetic: PC+1 wraps modulo 2^ADDR_W, so PC=FFFF gives OP_HI@0000. The high-byte carry in EA wraps (hi FF + carry -> 00).
- FIN:
  - DONE=1 and BUSY=1 for exactly one cycle, then IDLE.
  - EA, PC_ADV and PAGE_X are valid in the FIN cycle and held until the next acceptance.
- Latency from the acceptance edge to DONE, with MEM_RDY tied high:
  - IMM 1, ZP/ZP_X 2, ABS 3, ABS_X/ABS_Y 3 (4 with FIX), IND_X 4, IND_Y 4 (5 with FIX).

Test Plan:
- Reset mid-wait: start ABS, hold MEM_RDY=0 for 3 cycles, pull R low -> next cycle MEM_REQ=0, BUSY=0, EA=0. A fresh START then runs normally.
- ABS_X load, PC=0x0200, mem[0200]=F0, mem[0201]=12, X=0x20, PAGE_PENALTY=1 -> EA=0x1310, PAGE_X=1, PC_ADV=2, DONE 4 cycles after acceptance. Repeat with PAGE_PENALTY=0 -> 3 cycles.
- ABS_Y store, no crossing, mem=10,12, Y=01 -> EA=0x1211, PAGE_X=0, FIX taken, DONE at 4 cycles.
- IND_X, b=FF, X=00 -> pointer reads at 00FF then 0000 (page wrap). With mem[00FF]=34, mem[0000]=12 -> EA=0x1234, PC_ADV=1.
- IND_Y, b=80, ptr 0x12FF, Y=01, MEM_RDY toggling 1/0 -> EA=0x1300, PAGE_X=1, MEM_ADDR stable across wait cycles, DONE latency = 5 + number of wait cycles.
- ZP_X, b=F0, X=20 -> EA=0x0010, PAGE_X=0. START asserted while BUSY=1 is ignored. IMM with PC=FFFF -> EA=FFFF, DONE after 1 cycle.

Source files
------------

// File: rtl/ea_sequencer.sv
// Multi-cycle effective-address sequencer for the 6502-style core.
// Fetches operand and pointer bytes over a request/ready handshake and reports EA, operand length and page crossing.
module ea_sequencer #(
    parameter int DATA_W       = 8,
    parameter int ADDR_W       = 16,
    parameter int PAGE_PENALTY = 1
) (
    input  logic              CLK,
    input  logic              R,
    input  logic              START,
    input  logic [2:0]        MODE,
    input  logic              IS_STORE,
    input  logic [ADDR_W-1:0] PC_IN,
    input  logic [DATA_W-1:0] X_IN,
    input  logic [DATA_W-1:0] Y_IN,
    output logic              MEM_REQ,
    output logic [ADDR_W-1:0] MEM_ADDR,
    input  logic              MEM_RDY,
    input  logic [DATA_W-1:0] MEM_RDATA,
    output logic              BUSY,
    output logic              DONE,
    output logic [ADDR_W-1:0] EA,
    output logic [1:0]        PC_ADV,
    output logic              PAGE_X
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_OP_LO,
        S_OP_HI,
        S_PTR_LO,
        S_PTR_HI,
        S_FIX,
        S_FIN
    } state_t;

    localparam logic [2:0] M_IMM   = 3'd0;
    localparam logic [2:0] M_ZP    = 3'd1;
    localparam logic [2:0] M_ZP_X  = 3'd2;
    localparam logic [2:0] M_ABS   = 3'd3;
    localparam logic [2:0] M_ABS_X = 3'd4;
    localparam logic [2:0] M_ABS_Y = 3'd5;
    localparam logic [2:0] M_IND_X = 3'd6;
    localparam logic [2:0] M_IND_Y = 3'd7;

    localparam logic [DATA_W-1:0] ZERO_HI = '0;

    state_t            r_state;
    state_t            w_next;
    logic [2:0]        r_mode;
    logic              r_store;
    logic [ADDR_W-1:0] r_pc;
    logic [DATA_W-1:0] r_x;
    logic [DATA_W-1:0] r_y;
    logic [DATA_W-1:0] r_b;
    logic [DATA_W-1:0] r_pl;
    logic [ADDR_W-1:0] r_ea;
    logic [1:0]        r_pc_adv;
    logic              r_page_x;

    logic [DATA_W-1:0] w_idx;
    logic [DATA_W-1:0] w_base;
    logic [DATA_W:0]   w_sum;
    logic [DATA_W-1:0] w_hi;
    logic [DATA_W-1:0] w_zp;
    logic [DATA_W-1:0] w_zp1;
    logic [DATA_W-1:0] w_zpx;
    logic [ADDR_W-1:0] w_pc1;
    logic              w_fix;

    // Shared indexed adder: low byte (operand or pointer) plus index, carry rippled into the byte arriving now.
    assign w_idx  = (r_mode == M_ABS_Y || r_mode == M_IND_Y) ? r_y : r_x;
    assign w_base = (r_state == S_PTR_HI) ? r_pl : r_b;
    assign w_sum  = {1'b0, w_base} + {1'b0, w_idx};
    assign w_hi   = MEM_RDATA + DATA_W'(w_sum[DATA_W]);
    assign w_fix  = r_store | (w_sum[DATA_W] & (PAGE_PENALTY != 0));

    assign w_zp   = (r_mode == M_IND_X) ? r_b + r_x : r_b;
    assign w_zp1  = w_zp + DATA_W'(1);
    assign w_zpx  = MEM_RDATA + r_x;
    assign w_pc1  = r_pc + ADDR_W'(1);

    assign EA     = r_ea;
    assign PC_ADV = r_pc_adv;
    assign PAGE_X = r_page_x;

    always_ff @(posedge CLK) begin
        if (!R) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (START) begin
                    w_next = (MODE == M_IMM) ? S_FIN : S_OP_LO;
                end
            end
            S_OP_LO: begin
                if (MEM_RDY) begin
                    case (r_mode)
                        M_ZP, M_ZP_X:           w_next = S_FIN;
                        M_ABS, M_ABS_X, M_ABS_Y: w_next = S_OP_HI;
                        default:                w_next = S_PTR_LO;
                    endcase
                end
            end
            S_OP_HI: begin
                if (MEM_RDY) begin
                    w_next = (r_mode != M_ABS && w_fix) ? S_FIX : S_FIN;
                end
            end
            S_PTR_LO: begin
                if (MEM_RDY) begin
                    w_next = S_PTR_HI;
                end
            end
            S_PTR_HI: begin
                if (MEM_RDY) begin
                    w_next = (r_mode == M_IND_Y && w_fix) ? S_FIX : S_FIN;
                end
            end
            S_FIX:   w_next = S_FIN;
            S_FIN:   w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        MEM_REQ  = 1'b0;
        MEM_ADDR = '0;
        BUSY     = (r_state != S_IDLE);
        DONE     = (r_state == S_FIN);
        case (r_state)
            S_OP_LO: begin
                MEM_REQ  = 1'b1;
                MEM_ADDR = r_pc;
            end
            S_OP_HI: begin
                MEM_REQ  = 1'b1;
                MEM_ADDR = w_pc1;
            end
            S_PTR_LO: begin
                MEM_REQ  = 1'b1;
                MEM_ADDR = {ZERO_HI, w_zp};
            end
            S_PTR_HI: begin
                MEM_REQ  = 1'b1;
                MEM_ADDR = {ZERO_HI, w_zp1};
            end
            default: begin
                MEM_REQ  = 1'b0;
                MEM_ADDR = '0;
            end
        endcase
    end

    // Request latches and result registers; results only change when the final byte of a new request lands.
    always_ff @(posedge CLK) begin
        if (!R) begin
            r_mode   <= '0;
            r_store  <= 1'b0;
            r_pc     <= '0;
            r_x      <= '0;
            r_y      <= '0;
            r_b      <= '0;
            r_pl     <= '0;
            r_ea     <= '0;
            r_pc_adv <= '0;
            r_page_x <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (START) begin
                        r_mode  <= MODE;
                        r_store <= IS_STORE;
                        r_pc    <= PC_IN;
                        r_x     <= X_IN;
                        r_y     <= Y_IN;
                        if (MODE == M_IMM) begin
                            r_ea     <= PC_IN;
                            r_pc_adv <= 2'd1;
                            r_page_x <= 1'b0;
                        end
                    end
                end
                S_OP_LO: begin
                    if (MEM_RDY) begin
                        r_b <= MEM_RDATA;
                        if (r_mode == M_ZP) begin
                            r_ea     <= {ZERO_HI, MEM_RDATA};
                            r_pc_adv <= 2'd1;
                            r_page_x <= 1'b0;
                        end else if (r_mode == M_ZP_X) begin
                            r_ea     <= {ZERO_HI, w_zpx};
                            r_pc_adv <= 2'd1;
                            r_page_x <= 1'b0;
                        end
                    end
                end
                S_OP_HI: begin
                    if (MEM_RDY) begin
                        r_pc_adv <= 2'd2;
                        if (r_mode == M_ABS) begin
                            r_ea     <= {MEM_RDATA, r_b};
                            r_page_x <= 1'b0;
                        end else begin
                            r_ea     <= {w_hi, w_sum[DATA_W-1:0]};
                            r_page_x <= w_sum[DATA_W];
                        end
                    end
                end
                S_PTR_LO: begin
                    if (MEM_RDY) begin
                        r_pl <= MEM_RDATA;
                    end
                end
                S_PTR_HI: begin
                    if (MEM_RDY) begin
                        r_pc_adv <= 2'd1;
                        if (r_mode == M_IND_X) begin
                            r_ea     <= {MEM_RDATA, r_pl};
                            r_page_x <= 1'b0;
                        end else begin
                            r_ea     <= {w_hi, w_sum[DATA_W-1:0]};
                            r_page_x <= w_sum[DATA_W];
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ea_sequencer.sv
// Self-checking bench for ea_sequencer: one instance with the page penalty and one without, fed in lockstep
// from a shared memory model that inserts a configurable number of wait states per fetch.
module tb_ea_sequencer;

    logic        CLK;
    logic        R;
    logic        START;
    logic [2:0]  MODE;
    logic        IS_STORE;
    logic [15:0] PC_IN;
    logic [7:0]  X_IN;
    logic [7:0]  Y_IN;
    logic        MEM_RDY;

    logic        req0, req1, busy0, busy1, done0, done1, px0, px1;
    logic [15:0] addr0, addr1, ea0, ea1;
    logic [1:0]  adv0, adv1;
    logic [7:0]  rdata0, rdata1;

    logic [7:0]  mem [0:65535];

    int checks = 0;
    int fails  = 0;
    int waitCfg = 0;
    int waitCnt = 0;
    bit forceStall = 0;
    bit havePrev = 0;
    logic [15:0] prevAddr;

    typedef struct {
        logic [2:0]  mode;
        logic        store;
        logic [15:0] pc;
        logic [7:0]  x;
        logic [7:0]  y;
        int          waits;
        bit          poke;
        int          nf;
        logic [15:0] fa [3];
        logic [7:0]  fd [3];
        logic [15:0] ea;
        logic [1:0]  adv;
        logic        px;
        int          lat1;
        int          lat0;
    } vec_t;

    typedef struct {
        logic [15:0] ea;
        logic [1:0]  adv;
        logic        px;
        int          lat;
    } exp_t;

    vec_t        vecs[$];
    exp_t        sb0[$];
    exp_t        sb1[$];
    logic [15:0] addrQ[$];

    assign rdata0 = mem[addr0];
    assign rdata1 = mem[addr1];

    ea_sequencer #(.DATA_W(8), .ADDR_W(16), .PAGE_PENALTY(1)) dut1 (
        .CLK(CLK), .R(R), .START(START), .MODE(MODE), .IS_STORE(IS_STORE), .PC_IN(PC_IN),
        .X_IN(X_IN), .Y_IN(Y_IN), .MEM_REQ(req1), .MEM_ADDR(addr1), .MEM_RDY(MEM_RDY),
        .MEM_RDATA(rdata1), .BUSY(busy1), .DONE(done1), .EA(ea1), .PC_ADV(adv1), .PAGE_X(px1)
    );

    ea_sequencer #(.DATA_W(8), .ADDR_W(16), .PAGE_PENALTY(0)) dut0 (
        .CLK(CLK), .R(R), .START(START), .MODE(MODE), .IS_STORE(IS_STORE), .PC_IN(PC_IN),
        .X_IN(X_IN), .Y_IN(Y_IN), .MEM_REQ(req0), .MEM_ADDR(addr0), .MEM_RDY(MEM_RDY),
        .MEM_RDATA(rdata0), .BUSY(busy0), .DONE(done0), .EA(ea0), .PC_ADV(adv0), .PAGE_X(px0)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            fails++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    function automatic vec_t mkVec(input logic [2:0] mode, input logic store, input logic [15:0] pc,
                                   input logic [7:0] x, input logic [7:0] y, input int waits, input bit poke,
                                   input int nf, input logic [15:0] a0, input logic [7:0] d0,
                                   input logic [15:0] a1, input logic [7:0] d1, input logic [15:0] a2,
                                   input logic [7:0] d2, input logic [15:0] ea, input logic [1:0] adv,
                                   input logic px, input int lat1, input int lat0);
        vec_t v;
        v.mode = mode; v.store = store; v.pc = pc; v.x = x; v.y = y;
        v.waits = waits; v.poke = poke; v.nf = nf;
        v.fa[0] = a0; v.fa[1] = a1; v.fa[2] = a2;
        v.fd[0] = d0; v.fd[1] = d1; v.fd[2] = d2;
        v.ea = ea; v.adv = adv; v.px = px; v.lat1 = lat1; v.lat0 = lat0;
        return v;
    endfunction

    // Memory responder: each fetch is held off for waitCfg cycles, the address must not move meanwhile.
    always @(negedge CLK) begin
        if (!R) begin
            MEM_RDY  = 1'b0;
            waitCnt  = 0;
            havePrev = 0;
        end else begin
            checkOutput("lockstep_addr", 32'(addr1), 32'(addr0));
            if (!req0) begin
                checkOutput("idle_addr_zero", 32'(addr0), 32'h0);
                MEM_RDY  = 1'($urandom_range(0, 1));
                waitCnt  = 0;
                havePrev = 0;
            end else begin
                if (havePrev) checkOutput("addr_stable", 32'(addr0), 32'(prevAddr));
                if (forceStall || waitCnt < waitCfg) begin
                    MEM_RDY  = 1'b0;
                    waitCnt++;
                    havePrev = 1;
                    prevAddr = addr0;
                end else begin
                    MEM_RDY  = 1'b1;
                    waitCnt  = 0;
                    havePrev = 0;
                    if (addrQ.size() == 0) begin
                        checkOutput("extra_fetch", 32'(addr0), 32'hFFFFFFFF);
                    end else begin
                        checkOutput("fetch_addr", 32'(addr0), 32'(addrQ.pop_front()));
                    end
                end
            end
        end
    end

    task automatic checkDone(input string tag, input exp_t e, input logic [15:0] ea, input logic [1:0] adv,
                             input logic px, input int cycle);
        checkOutput({tag, "_ea"}, 32'(ea), 32'(e.ea));
        checkOutput({tag, "_pc_adv"}, 32'(adv), 32'(e.adv));
        checkOutput({tag, "_page_x"}, 32'(px), 32'(e.px));
        checkOutput({tag, "_latency"}, 32'(cycle), 32'(e.lat));
    endtask

    task automatic applyStimulus(input vec_t v);
        exp_t e;
        int   cycle;
        bit   got0, got1;
        @(negedge CLK);
        for (int i = 0; i < v.nf; i++) begin
            mem[v.fa[i]] = v.fd[i];
            addrQ.push_back(v.fa[i]);
        end
        waitCfg  = v.waits;
        MODE     = v.mode;
        IS_STORE = v.store;
        PC_IN    = v.pc;
        X_IN     = v.x;
        Y_IN     = v.y;
        START    = 1'b1;
        @(posedge CLK);
        e.ea = v.ea; e.adv = v.adv; e.px = v.px;
        e.lat = v.lat1 + v.waits * v.nf;
        sb1.push_back(e);
        e.lat = v.lat0 + v.waits * v.nf;
        sb0.push_back(e);
        cycle = 0; got0 = 0; got1 = 0;
        while (!(got0 && got1) && cycle < 60) begin
            @(negedge CLK);
            cycle++;
            START    = (v.poke && cycle <= 2);
            MODE     = 3'($urandom);
            IS_STORE = 1'($urandom);
            PC_IN    = 16'($urandom);
            X_IN     = 8'($urandom);
            Y_IN     = 8'($urandom);
            if (done1 && !got1) begin
                got1 = 1;
                if (sb1.size() == 0) checkOutput("unexpected_done_pp1", 32'h1, 32'h0);
                else checkDone("pp1", sb1.pop_front(), ea1, adv1, px1, cycle);
            end
            if (done0 && !got0) begin
                got0 = 1;
                if (sb0.size() == 0) checkOutput("unexpected_done_pp0", 32'h1, 32'h0);
                else checkDone("pp0", sb0.pop_front(), ea0, adv0, px0, cycle);
            end
        end
        START = 1'b0;
        checkOutput("done_seen_pp1", 32'(got1), 32'h1);
        checkOutput("done_seen_pp0", 32'(got0), 32'h1);
        checkOutput("fetch_count", 32'(addrQ.size()), 32'h0);
        addrQ.delete();
        sb0.delete();
        sb1.delete();
        @(negedge CLK);
        checkOutput("idle_after_pp1", 32'(busy1), 32'h0);
        checkOutput("idle_after_pp0", 32'(busy0), 32'h0);
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
        R = 1'b0; START = 1'b0; MODE = '0; IS_STORE = 1'b0; PC_IN = '0; X_IN = '0; Y_IN = '0;
        MEM_RDY = 1'b0;

        // mode st pc x y waits poke nf  a0 d0  a1 d1  a2 d2  ea adv px lat(pp1) lat(pp0)
        vecs.push_back(mkVec(3'd0, 0, 16'hFFFF, 8'h00, 8'h00, 0, 0, 0, 16'h0000, 8'h00, 16'h0000, 8'h00,
                             16'h0000, 8'h00, 16'hFFFF, 2'd1, 0, 1, 1));
        vecs.push_back(mkVec(3'd1, 0, 16'h0300, 8'h11, 8'h22, 0, 0, 1, 16'h0300, 8'h45, 16'h0000, 8'h00,
                             16'h0000, 8'h00, 16'h0045, 2'd1, 0, 2, 2));
        vecs.push_back(mkVec(3'd2, 0, 16'h0310, 8'h20, 8'h00, 0, 0, 1, 16'h0310, 8'hF0, 16'h0000, 8'h00,
                             16'h0000, 8'h00, 16'h0010, 2'd1, 0, 2, 2));
        vecs.push_back(mkVec(3'd3, 0, 16'hFFFF, 8'h00, 8'h00, 0, 0, 2, 16'hFFFF, 8'hCD, 16'h0000, 8'hAB,
                             16'h0000, 8'h00, 16'hABCD, 2'd2, 0, 3, 3));
        vecs.push_back(mkVec(3'd4, 0, 16'h0200, 8'h20, 8'h00, 0, 0, 2, 16'h0200, 8'hF0, 16'h0201, 8'h12,
                             16'h0000, 8'h00, 16'h1310, 2'd2, 1, 4, 3));
        vecs.push_back(mkVec(3'd5, 1, 16'h0210, 8'h00, 8'h01, 0, 0, 2, 16'h0210, 8'h10, 16'h0211, 8'h12,
                             16'h0000, 8'h00, 16'h1211, 2'd2, 0, 4, 4));
        vecs.push_back(mkVec(3'd4, 0, 16'h0220, 8'h03, 8'h00, 0, 0, 2, 16'h0220, 8'h05, 16'h0221, 8'h40,
                             16'h0000, 8'h00, 16'h4008, 2'd2, 0, 3, 3));
        vecs.push_back(mkVec(3'd4, 0, 16'h0230, 8'h01, 8'h00, 0, 0, 2, 16'h0230, 8'hFF, 16'h0231, 8'hFF,
                             16'h0000, 8'h00, 16'h0000, 2'd2, 1, 4, 3));
        vecs.push_back(mkVec(3'd6, 0, 16'h0240, 8'h00, 8'h00, 0, 0, 3, 16'h0240, 8'hFF, 16'h00FF, 8'h34,
                             16'h0000, 8'h12, 16'h1234, 2'd1, 0, 4, 4));
        vecs.push_back(mkVec(3'd6, 0, 16'h0250, 8'h05, 8'h00, 0, 0, 3, 16'h0250, 8'h10, 16'h0015, 8'h78,
                             16'h0016, 8'h56, 16'h5678, 2'd1, 0, 4, 4));
        vecs.push_back(mkVec(3'd6, 0, 16'h02A0, 8'h10, 8'h00, 0, 0, 3, 16'h02A0, 8'hF8, 16'h0008, 8'hEF,
                             16'h0009, 8'hBE, 16'hBEEF, 2'd1, 0, 4, 4));
        vecs.push_back(mkVec(3'd7, 0, 16'h0260, 8'h00, 8'h01, 1, 1, 3, 16'h0260, 8'h80, 16'h0080, 8'hFF,
                             16'h0081, 8'h12, 16'h1300, 2'd1, 1, 5, 4));
        vecs.push_back(mkVec(3'd7, 1, 16'h0270, 8'h00, 8'h05, 0, 0, 3, 16'h0270, 8'hFF, 16'h00FF, 8'h00,
                             16'h0000, 8'h20, 16'h2005, 2'd1, 0, 5, 5));
        vecs.push_back(mkVec(3'd1, 0, 16'h0280, 8'h00, 8'h00, 2, 1, 1, 16'h0280, 8'h9A, 16'h0000, 8'h00,
                             16'h0000, 8'h00, 16'h009A, 2'd1, 0, 2, 2));
        vecs.push_back(mkVec(3'd5, 0, 16'h0290, 8'h00, 8'h90, 1, 0, 2, 16'h0290, 8'h80, 16'h0291, 8'h7F,
                             16'h0000, 8'h00, 16'h8010, 2'd2, 1, 4, 3));
        vecs.push_back(mkVec(3'd2, 1, 16'h02B0, 8'h05, 8'h00, 0, 0, 1, 16'h02B0, 8'hFB, 16'h0000, 8'h00,
                             16'h0000, 8'h00, 16'h0000, 2'd1, 0, 2, 2));
        vecs.push_back(mkVec(3'd3, 1, 16'h02C0, 8'h00, 8'h00, 0, 0, 2, 16'h02C0, 8'h34, 16'h02C1, 8'h12,
                             16'h0000, 8'h00, 16'h1234, 2'd2, 0, 3, 3));

        repeat (3) @(negedge CLK);
        checkOutput("reset_busy", 32'(busy1), 32'h0);
        checkOutput("reset_done", 32'(done1), 32'h0);
        checkOutput("reset_req", 32'(req1), 32'h0);
        checkOutput("reset_ea", 32'(ea1), 32'h0);
        checkOutput("reset_pc_adv", 32'(adv1), 32'h0);
        checkOutput("reset_page_x", 32'(px1), 32'h0);
        R = 1'b1;

        for (int i = 0; i < 7; i++) applyStimulus(vecs[i]);

        // Abort an ABS fetch stuck in wait states, then confirm a fresh request still works.
        @(negedge CLK);
        forceStall = 1;
        MODE = 3'd3; IS_STORE = 1'b0; PC_IN = 16'h0400; START = 1'b1;
        @(posedge CLK);
        @(negedge CLK);
        START = 1'b0;
        checkOutput("stall_req", 32'(req1), 32'h1);
        repeat (2) @(negedge CLK);
        R = 1'b0;
        @(posedge CLK);
        @(negedge CLK);
        checkOutput("abort_req", 32'(req1), 32'h0);
        checkOutput("abort_busy", 32'(busy1), 32'h0);
        checkOutput("abort_ea", 32'(ea1), 32'h0);
        checkOutput("abort_done", 32'(done1), 32'h0);
        checkOutput("abort_busy_pp0", 32'(busy0), 32'h0);
        checkOutput("abort_ea_pp0", 32'(ea0), 32'h0);
        R = 1'b1;
        forceStall = 0;
        applyStimulus(vecs[3]);

        for (int i = 7; i < vecs.size(); i++) applyStimulus(vecs[i]);

        repeat (2) @(negedge CLK);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
